instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Drives the microinstruction decoder. Generates the one-hot Phase0..Phase3 timing ring and holds the instruction register that feeds InstrIn0..InstrIn3.
- Owns the program counter and the memory address, and consumes the decoder's LoadInst, ProgCount and ReadMem strobes.
- Provides run, halt, single-step, memory-wait and illegal-opcode fault control.

Parameters:
- ADDR_W, 4, program counter and address width in bits.
- OPC_W, 4, instruction/opcode width. It is fixed at 4 to match the decoder inputs.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Run  in  1  synchronous start request; pulse or level.
- Step  in  1  synchronous single-instruction request; honoured only in STOP.
- HaltReq  in  1  stop once the current instruction completes.
- MemReady  in  1  memory data valid; stalls a ReadMem phase while low.
- DataIn  in  OPC_W  instruction nibble from memory.
- LoadInst  in  1  decoder strobe: load the instruction register.
- ProgCount  in  1  decoder strobe: increment the program counter.
- ReadMem  in  1  decoder strobe: a memory read is in progress this phase.
- Phase0..Phase3  out  1 each  one-hot phase outputs.
- InstrIn0..InstrIn3  out  1 each  instruction register bits 0..3.
- Address  out  ADDR_W  current program counter.
- Running  out  1  high in RUN or STEP.
- Illegal  out  1  sticky fault flag.
- PcWrap  out  1  one-cycle pulse when the program counter wraps.

Behaviour:
- Reset, asynchronous and active-low, clears:
  - state to STOP;
  - all Phase outputs to 0;
  - instruction register to 0000 (NOP);
  - program counter to 0;
  - Running, Illegal and PcWrap to 0.
- States: STOP, RUN, STEP, FAULT.
- STOP:
  - Phases are all 0.
  - Run=1 and HaltReq=0 moves to RUN. Phase0=1 from the next cycle.
  - Else Step=1 moves to STEP. Phase0=1 from the next cycle.
  - Run has priority over Step.
- Phase ring in RUN and STEP:
  - Sequence is Phase0, Phase1, Phase2, Phase3, then back to Phase0. Each phase lasts one cycle.
  - Exactly one phase is high at any time.
- Stall: while ReadMem=1 and MemReady=0, the current phase holds. During a stall:
  - the program counter does not increment;
  - the instruction register does not load.
- Instruction register: loads DataIn on an edge where LoadInst=1, the ring is not stalled and the state is RUN or STEP.
- Program counter:
  - Adds 1 modulo 2^ADDR_W on an edge where ProgCount=1 and the ring is not stalled.
  - At the all-ones to 0 transition, PcWrap=1 for exactly one cycle.
  - LoadInst and ProgCount asserted together both take effect.
- Illegal-opcode check:
  - Performed on the edge leaving Phase1.
  - Defined opcodes: NOP 0000, ADD 0001, SUB 0010, OUT 0011, IN 0100, LOAD 0101.
  - If the instruction register holds 0110 to 1111: move to FAULT, Illegal=1, all phases 0. The program counter keeps its value.
- FAULT:
  - Holds until Run=1, which clears Illegal and moves to RUN starting at Phase0.
  - Step is ignored.
- End of instruction (edge leaving Phase3):
  - STEP always returns to STOP.
  - RUN returns to STOP if HaltReq=1 has been seen since Phase0; otherwise Phase0 follows.
- Halt handling:
  - HaltReq is latched and never truncates an instruction mid-phase.
  - HaltReq and Run asserted together in STOP: HaltReq wins and the state stays STOP.
- Run or Step asserted during RUN or STEP is ignored.
- Running=1 exactly when the state is RUN or STEP.
- Address always equals the program counter. No combinational path from inputs to Address.
- Phase outputs and InstrIn are registered. No glitches.

Decomposition:
- Package instr_seq_pkg holds:
  - the opcode constants OPC_NOP through OPC_LOAD, and OPC_LAST_LEGAL=0101;
  - the state enum {STOP, RUN, STEP, FAULT};
  - the phase index constants PH0 to PH3.
- Sub-module phase_ring: a 4-bit one-hot ring with start, hold (stall) and clear inputs, and a last-phase indication.
  - It is instantiated once.
  - The FSM, instruction register and program counter live in instr_sequencer.

Test Plan:
- Reset then Run=1 for one cycle with MemReady=1 and DataIn=0001 → phases follow 1000, 0100, 0010, 0001 (Phase0..Phase3), then repeat. Running=1, instruction register=0001 after the first LoadInst.
- ProgCount pulsed in 16 consecutive instructions, ADDR_W=4, starting at Address=0 → Address returns to 0, PcWrap=1 for exactly one cycle at the wrap.
- In Phase0 with ReadMem=1, MemReady=0 for 3 cycles, then MemReady=1 → Phase0 is held 4 cycles total. The program counter and instruction register update only on the released edge.
- DataIn=0111 loaded in Phase0 → on leaving Phase1: Illegal=1, state FAULT, phases all 0, Address unchanged. A later Run=1 → Illegal=0 and Phase0=1.
- In STOP, Step=1 for one cycle → exactly 4 phase cycles, then STOP with Running=0. Run and HaltReq together in STOP → remains in STOP.
- HaltReq=1 pulsed during Phase1 in RUN → Phase2 and Phase3 complete, then STOP. ResetN=0 asserted mid-Phase2 → all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode, state and phase-index definitions for the instruction sequencer.
package instr_seq_pkg;

  localparam logic [3:0] OPC_NOP        = 4'b0000;
  localparam logic [3:0] OPC_ADD        = 4'b0001;
  localparam logic [3:0] OPC_SUB        = 4'b0010;
  localparam logic [3:0] OPC_OUT        = 4'b0011;
  localparam logic [3:0] OPC_IN         = 4'b0100;
  localparam logic [3:0] OPC_LOAD       = 4'b0101;
  localparam logic [3:0] OPC_LAST_LEGAL = OPC_LOAD;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    FAULT = 2'd3
  } seq_state_e;

  localparam int PH0 = 0;
  localparam int PH1 = 1;
  localparam int PH2 = 2;
  localparam int PH3 = 3;

  function automatic logic opc_is_legal(input logic [3:0] opc);
    return opc <= OPC_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/instr_sequencer_phase_ring.sv
// One-hot four-phase timing ring with start, stall-hold and clear controls.
module phase_ring
  import instr_seq_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       hold_i,
  input  logic       clear_i,
  output logic [3:0] phase_o,
  output logic       last_o
);

  logic [3:0] ring_q, ring_d;

  // Clear beats start; an idle (all-zero) ring never rotates on its own.
  always_comb begin
    ring_d = ring_q;
    if (clear_i) begin
      ring_d = '0;
    end else if (start_i) begin
      ring_d      = '0;
      ring_d[PH0] = 1'b1;
    end else if (!hold_i && (ring_q != '0)) begin
      ring_d = {ring_q[2:0], ring_q[3]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ring_q <= '0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign phase_o = ring_q;
  assign last_o  = ring_q[PH3];

endmodule

// File: rtl/instr_sequencer.sv
// Run/halt/step/fault sequencer: phase ring, instruction register and program counter.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Run,
  input  logic              Step,
  input  logic              HaltReq,
  input  logic              MemReady,
  input  logic [OPC_W-1:0]  DataIn,
  input  logic              LoadInst,
  input  logic              ProgCount,
  input  logic              ReadMem,
  output logic              Phase0,
  output logic              Phase1,
  output logic              Phase2,
  output logic              Phase3,
  output logic              InstrIn0,
  output logic              InstrIn1,
  output logic              InstrIn2,
  output logic              InstrIn3,
  output logic [ADDR_W-1:0] Address,
  output logic              Running,
  output logic              Illegal,
  output logic              PcWrap
);

  seq_state_e        state_q, state_d;
  logic              illegal_q, illegal_d;
  logic              halt_q, halt_d;
  logic [OPC_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_d;

  logic       ring_start, ring_clear, ring_last;
  logic [3:0] phase;
  logic       stall, active, adv, leave_p1, leave_p3, pc_inc;

  assign stall    = ReadMem & ~MemReady;
  assign active   = (state_q == RUN) || (state_q == STEP);
  assign adv      = active & ~stall;
  assign leave_p1 = adv & phase[PH1];
  assign leave_p3 = adv & ring_last;
  assign pc_inc   = adv & ProgCount;

  phase_ring u_ring (
    .clk_i   (Clock),
    .rst_ni  (ResetN),
    .start_i (ring_start),
    .hold_i  (stall),
    .clear_i (ring_clear),
    .phase_o (phase),
    .last_o  (ring_last)
  );

  // Halt requests are remembered so the instruction always finishes its Phase3.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    halt_d     = halt_q;
    ring_start = 1'b0;
    ring_clear = 1'b0;
    if (active && HaltReq) halt_d = 1'b1;
    unique case (state_q)
      STOP: begin
        if (Run && !HaltReq) begin
          state_d    = RUN;
          ring_start = 1'b1;
          halt_d     = 1'b0;
        end else if (Step) begin
          state_d    = STEP;
          ring_start = 1'b1;
          halt_d     = 1'b0;
        end
      end
      RUN, STEP: begin
        if (leave_p1 && !opc_is_legal(ir_q)) begin
          state_d    = FAULT;
          illegal_d  = 1'b1;
          ring_clear = 1'b1;
          halt_d     = 1'b0;
        end else if (leave_p3 && ((state_q == STEP) || halt_q || HaltReq)) begin
          state_d    = STOP;
          ring_clear = 1'b1;
          halt_d     = 1'b0;
        end
      end
      FAULT: begin
        if (Run) begin
          state_d    = RUN;
          illegal_d  = 1'b0;
          ring_start = 1'b1;
        end
      end
      default: state_d = STOP;
    endcase
  end

  always_comb begin
    ir_d   = ir_q;
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (adv && LoadInst) ir_d = DataIn;
    if (pc_inc) begin
      pc_d   = pc_q + ADDR_W'(1);
      wrap_d = &pc_q;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= STOP;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
      ir_q      <= OPC_NOP;
      pc_q      <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      halt_q    <= halt_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      wrap_q    <= wrap_d;
    end
  end

  assign Phase0   = phase[PH0];
  assign Phase1   = phase[PH1];
  assign Phase2   = phase[PH2];
  assign Phase3   = phase[PH3];
  assign InstrIn0 = ir_q[0];
  assign InstrIn1 = ir_q[1];
  assign InstrIn2 = ir_q[2];
  assign InstrIn3 = ir_q[3];
  assign Address  = pc_q;
  assign Running  = active;
  assign Illegal  = illegal_q;
  assign PcWrap   = wrap_q;

endmodule
